gcn_result_collector: RTL and testbench



---
 rtl/gcn_result_collector.sv | 218 +++++++++++++++++++++
 tb/tb_gcn_result_collector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : gcn_result_collector
// Brief    : Captures a GCN result frame into two column banks with optional
//            ReLU, tracks per-column max/argmax, offers a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module gcn_result_collector #(
    parameter int DATA_BITS = 16,
    parameter int NUM_ROWS  = 100,
    parameter int ROW_BITS  = 7,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_rd_en,
    input  logic                 i_rd_sel,
    input  logic [ROW_BITS-1:0]  i_rd_addr,
    output logic [DATA_BITS-1:0] o_rd_data,
    output logic                 o_rd_valid,
    output logic [7:0]           o_col_idx_1,
    output logic [7:0]           o_col_idx_2,
    output logic [DATA_BITS-1:0] o_max_1,
    output logic [DATA_BITS-1:0] o_max_2,
    output logic [ROW_BITS-1:0]  o_argmax_1,
    output logic [ROW_BITS-1:0]  o_argmax_2,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int                   WORD_BITS   = ROW_BITS + 1;
    localparam logic [WORD_BITS-1:0] c_LAST_WORD = WORD_BITS'(2 * NUM_ROWS - 1);
    localparam logic [ROW_BITS:0]    c_NUM_ROWS  = (ROW_BITS + 1)'(NUM_ROWS);
    localparam logic [DATA_BITS-1:0] c_MAX_INIT  = RELU_EN ? {DATA_BITS{1'b0}}
                                                           : {1'b1, {(DATA_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state_q,   w_state_d;
    logic [WORD_BITS-1:0]   r_word_q,    w_word_d;
    logic [7:0]             r_col1_q,    w_col1_d;
    logic [7:0]             r_col2_q,    w_col2_d;
    logic [DATA_BITS-1:0]   r_max1_q,    w_max1_d;
    logic [DATA_BITS-1:0]   r_max2_q,    w_max2_d;
    logic [ROW_BITS-1:0]    r_argmax1_q, w_argmax1_d;
    logic [ROW_BITS-1:0]    r_argmax2_q, w_argmax2_d;
    logic                   r_err_q,     w_err_d;
    logic [DATA_BITS-1:0]   r_rd_data_q;
    logic                   r_rd_valid_q;

    logic [DATA_BITS-1:0]   r_bank1_q [NUM_ROWS];
    logic [DATA_BITS-1:0]   r_bank2_q [NUM_ROWS];

    logic                   w_wr_en;
    logic                   w_wr_bank2;
    logic [ROW_BITS-1:0]    w_wr_row;
    logic [DATA_BITS-1:0]   w_val;

    always_comb begin
        w_state_d   = r_state_q;
        w_word_d    = r_word_q;
        w_col1_d    = r_col1_q;
        w_col2_d    = r_col2_q;
        w_max1_d    = r_max1_q;
        w_max2_d    = r_max2_q;
        w_argmax1_d = r_argmax1_q;
        w_argmax2_d = r_argmax2_q;
        w_err_d     = r_err_q;
        w_wr_en     = 1'b0;
        // Even words feed bank 1, odd words bank 2, both for row word/2.
        w_wr_bank2  = r_word_q[0];
        w_wr_row    = r_word_q[WORD_BITS-1:1];
        w_val       = (RELU_EN && i_data[DATA_BITS-1]) ? {DATA_BITS{1'b0}} : i_data;

        if (i_start) begin
            w_err_d = 1'b0;
        end

        case (r_state_q)
            S_IDLE: begin
                if (i_valid) begin
                    w_err_d = 1'b1;
                end
                if (i_start) begin
                    w_state_d = S_HEADER;
                    w_word_d  = '0;
                end
            end
            S_HEADER: begin
                if (i_start) begin
                    w_err_d  = 1'b1;
                    w_word_d = '0;
                end else if (i_valid) begin
                    w_col1_d    = i_data[7:0];
                    w_col2_d    = i_data[15:8];
                    w_max1_d    = c_MAX_INIT;
                    w_max2_d    = c_MAX_INIT;
                    w_argmax1_d = '0;
                    w_argmax2_d = '0;
                    w_word_d    = '0;
                    w_state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (i_start) begin
                    w_err_d   = 1'b1;
                    w_word_d  = '0;
                    w_state_d = S_HEADER;
                end else if (i_valid) begin
                    w_wr_en = 1'b1;
                    // Strict compare so an equal value keeps the earlier row.
                    if (!w_wr_bank2) begin
                        if ($signed(w_val) > $signed(r_max1_q)) begin
                            w_max1_d    = w_val;
                            w_argmax1_d = w_wr_row;
                        end
                    end else begin
                        if ($signed(w_val) > $signed(r_max2_q)) begin
                            w_max2_d    = w_val;
                            w_argmax2_d = w_wr_row;
                        end
                    end
                    if (r_word_q == c_LAST_WORD) begin
                        w_word_d  = '0;
                        w_state_d = S_DONE;
                    end else begin
                        w_word_d = r_word_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (i_valid) begin
                    w_err_d = 1'b1;
                end
                w_word_d  = '0;
                w_state_d = i_start ? S_HEADER : S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
                w_word_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_word_q    <= '0;
            r_col1_q    <= '0;
            r_col2_q    <= '0;
            r_max1_q    <= '0;
            r_max2_q    <= '0;
            r_argmax1_q <= '0;
            r_argmax2_q <= '0;
            r_err_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_word_q    <= w_word_d;
            r_col1_q    <= w_col1_d;
            r_col2_q    <= w_col2_d;
            r_max1_q    <= w_max1_d;
            r_max2_q    <= w_max2_d;
            r_argmax1_q <= w_argmax1_d;
            r_argmax2_q <= w_argmax2_d;
            r_err_q     <= w_err_d;
        end
    end

    // Bank storage intentionally survives reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (w_wr_bank2) begin
                r_bank2_q[w_wr_row] <= w_val;
            end else begin
                r_bank1_q[w_wr_row] <= w_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid_q <= 1'b0;
            r_rd_data_q  <= '0;
        end else begin
            r_rd_valid_q <= i_rd_en;
            if (i_rd_en) begin
                if ({1'b0, i_rd_addr} < c_NUM_ROWS) begin
                    r_rd_data_q <= i_rd_sel ? r_bank2_q[i_rd_addr] : r_bank1_q[i_rd_addr];
                end else begin
                    r_rd_data_q <= '0;
                end
            end
        end
    end

    assign o_rd_data   = r_rd_data_q;
    assign o_rd_valid  = r_rd_valid_q;
    assign o_col_idx_1 = r_col1_q;
    assign o_col_idx_2 = r_col2_q;
    assign o_max_1     = r_max1_q;
    assign o_max_2     = r_max2_q;
    assign o_argmax_1  = r_argmax1_q;
    assign o_argmax_2  = r_argmax2_q;
    assign o_busy      = (r_state_q == S_HEADER) || (r_state_q == S_DATA);
    assign o_done      = (r_state_q == S_DONE);
    assign o_err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcn_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcn_result_collector
// Brief    : Scoreboard bench for gcn_result_collector (ReLU on and off).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcn_result_collector;

    localparam int NR = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic        rd_en_a = 1'b0;
    logic        rd_en_b = 1'b0;
    logic        rd_sel = 1'b0;
    logic [6:0]  rd_addr = '0;

    logic [15:0] rd_data_a, rd_data_b, max1_a, max2_a, max1_b, max2_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [7:0]  col1_a, col2_a, col1_b, col2_b;
    logic [6:0]  amax1_a, amax2_a, amax1_b, amax2_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          t_done = 0;
    int          t_start = 0;
    int          base;
    bit          err_at_start;
    bit          bok;
    logic [15:0] q_a [$];
    logic [15:0] q_b [$];

    gcn_result_collector #(.DATA_BITS(16), .NUM_ROWS(NR), .ROW_BITS(7), .RELU_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .i_start(start), .i_valid(valid), .i_data(data),
        .i_rd_en(rd_en_a), .i_rd_sel(rd_sel), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a),
        .o_col_idx_1(col1_a), .o_col_idx_2(col2_a),
        .o_max_1(max1_a), .o_max_2(max2_a), .o_argmax_1(amax1_a), .o_argmax_2(amax2_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a)
    );

    gcn_result_collector #(.DATA_BITS(16), .NUM_ROWS(NR), .ROW_BITS(7), .RELU_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .i_start(start), .i_valid(valid), .i_data(data),
        .i_rd_en(rd_en_b), .i_rd_sel(rd_sel), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b),
        .o_col_idx_1(col1_b), .o_col_idx_2(col2_b),
        .o_max_1(max1_b), .o_max_2(max2_b), .o_argmax_1(amax1_b), .o_argmax_2(amax2_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_a_unexpected: got 0x%0h, expected no read response", rd_data_a);
            end else begin
                chk("rd_a", {16'h0, rd_data_a}, {16'h0, q_a.pop_front()});
            end
        end
        if (rd_valid_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_b_unexpected: got 0x%0h, expected no read response", rd_data_b);
            end else begin
                chk("rd_b", {16'h0, rd_data_b}, {16'h0, q_b.pop_front()});
            end
        end
        if (done_a) begin
            done_cnt++;
            t_done = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word_val(input int pat, input int i);
        int r;
        r = i / 2;
        case (pat)
            0:       word_val = (i % 2 == 0) ? 16'(r) : 16'(-r);
            1:       word_val = (i % 2 == 0) ? (((r == 10) || (r == 40)) ? 16'h0100 : 16'hFFF0)
                                             : 16'h8001;
            default: word_val = (i % 2 == 0) ? 16'(r + 1000) : 16'(r + 2000);
        endcase
    endfunction

    task automatic rd(input bit b, input bit sel, input int addr, input logic [15:0] exp);
        rd_sel  = sel;
        rd_addr = 7'(addr);
        if (b) begin
            rd_en_b = 1'b1;
            q_b.push_back(exp);
        end else begin
            rd_en_a = 1'b1;
            q_a.push_back(exp);
        end
        step();
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    // n_words data words; optionally reads bank1[rw_row] of dut_a while it is written.
    task automatic send_frame(input int pat, input logic [15:0] hdr, input bit stalls,
                              input int n_words, input int rw_row, input logic [15:0] rw_old,
                              output bit busy_ok);
        busy_ok = 1'b1;
        t_start = cyc;
        start   = 1'b1;
        step();
        start   = 1'b0;
        err_at_start = err_a;
        busy_ok &= busy_a;
        while (stalls && ($urandom_range(1, 0) == 1)) begin
            data = 16'($urandom);
            step();
            busy_ok &= busy_a;
        end
        valid = 1'b1;
        data  = hdr;
        step();
        valid = 1'b0;
        busy_ok &= busy_a;
        for (int i = 0; i < n_words; i++) begin
            while (stalls && ($urandom_range(1, 0) == 1)) begin
                data = 16'($urandom);
                step();
                busy_ok &= busy_a;
            end
            valid = 1'b1;
            data  = word_val(pat, i);
            if ((rw_row >= 0) && (i == 2 * rw_row)) begin
                rd_sel  = 1'b0;
                rd_addr = 7'(rw_row);
                rd_en_a = 1'b1;
                q_a.push_back(rw_old);
            end
            step();
            valid   = 1'b0;
            rd_en_a = 1'b0;
            if (i != 2 * NR - 1) busy_ok &= busy_a;
        end
    endtask

    initial begin
        repeat (3) step();
        chk("rst_ctrl_a", {28'h0, busy_a, done_a, err_a, rd_valid_a}, 32'h0);
        chk("rst_max_a", {max1_a, max2_a}, 32'h0);
        chk("rst_misc_a", {rd_data_a, col2_a, col1_a}, 32'h0);
        chk("rst_amax_a", {18'h0, amax1_a, amax2_a}, 32'h0);
        chk("rst_max_b", {max1_b, max2_b}, 32'h0);
        rst = 1'b0;
        step();

        // Nominal frame, ReLU on.
        send_frame(0, 16'h0302, 1'b0, 2 * NR, -1, 16'h0, bok);
        chk("col_idx", {16'h0, col2_a, col1_a}, 32'h0302);
        chk("busy_nominal", {31'h0, bok}, 32'h1);
        step();
        step();
        chk("done_count_1", done_cnt, 1);
        chk("done_latency", t_done - t_start, 202);
        rd(1'b0, 1'b0, 57, 16'd57);
        rd(1'b0, 1'b1, 57, 16'd0);
        chk("max1_nom", {16'h0, max1_a}, 32'd99);
        chk("amax1_nom", {25'h0, amax1_a}, 32'd99);
        chk("max2_nom", {16'h0, max2_a}, 32'd0);
        chk("amax2_nom", {25'h0, amax2_a}, 32'd0);

        // Ties and negatives; dut_b has ReLU off.
        send_frame(1, 16'h0504, 1'b0, 2 * NR, -1, 16'h0, bok);
        chk("col_idx_b", {16'h0, col2_b, col1_b}, 32'h0504);
        chk("max1_b", {16'h0, max1_b}, 32'h0100);
        chk("amax1_b", {25'h0, amax1_b}, 32'd10);
        chk("max2_b", {16'h0, max2_b}, 32'h8001);
        chk("amax2_b", {25'h0, amax2_b}, 32'd0);
        chk("max1_relu", {16'h0, max1_a}, 32'h0100);
        chk("amax1_relu", {25'h0, amax1_a}, 32'd10);
        chk("max2_relu", {16'h0, max2_a}, 32'h0);

        // Stalled frame, started during the DONE cycle of the previous one.
        send_frame(0, 16'h0302, 1'b1, 2 * NR, -1, 16'h0, bok);
        chk("start_in_done_err", {31'h0, err_at_start}, 32'h0);
        chk("busy_stalls", {31'h0, bok}, 32'h1);
        step();
        step();
        chk("err_after_stall", {31'h0, err_a}, 32'h0);
        rd(1'b0, 1'b0, 57, 16'd57);
        rd(1'b0, 1'b1, 57, 16'd0);
        rd(1'b0, 1'b0, 99, 16'd99);
        rd(1'b1, 1'b1, 5, 16'hFFFB);
        chk("max1_stall", {16'h0, max1_a}, 32'd99);
        chk("amax1_stall", {25'h0, amax1_a}, 32'd99);
        chk("max2_stall", {16'h0, max2_a}, 32'd0);
        chk("amax2_stall", {25'h0, amax2_a}, 32'd0);

        // Abort after 37 data words, then a full frame.
        base = done_cnt;
        send_frame(2, 16'h0706, 1'b0, 37, -1, 16'h0, bok);
        send_frame(2, 16'h0706, 1'b0, 2 * NR, 20, 16'd20, bok);
        chk("abort_err", {31'h0, err_at_start}, 32'h1);
        step();
        step();
        chk("done_count_abort", done_cnt - base, 1);
        chk("err_sticky", {31'h0, err_a}, 32'h1);
        rd(1'b0, 1'b0, 20, 16'd1020);
        rd(1'b0, 1'b1, 20, 16'd2020);
        rd(1'b0, 1'b0, 99, 16'd1099);
        chk("max1_abort", {16'h0, max1_a}, 32'd1099);
        chk("amax1_abort", {25'h0, amax1_a}, 32'd99);
        chk("max2_abort", {16'h0, max2_a}, 32'd2099);
        chk("amax2_abort", {25'h0, amax2_a}, 32'd99);

        // Start clears error; re-abort; reset mid-DATA; stray word in IDLE.
        send_frame(2, 16'h0908, 1'b0, 10, -1, 16'h0, bok);
        chk("err_cleared", {31'h0, err_at_start}, 32'h0);
        send_frame(2, 16'h0908, 1'b0, 10, -1, 16'h0, bok);
        chk("reabort_err", {31'h0, err_at_start}, 32'h1);
        rst = 1'b1;
        step();
        chk("rst_mid_busy", {31'h0, busy_a}, 32'h0);
        chk("rst_mid_err", {31'h0, err_a}, 32'h0);
        rst = 1'b0;
        step();
        valid = 1'b1;
        data  = 16'hBEEF;
        step();
        valid = 1'b0;
        chk("stray_err", {31'h0, err_a}, 32'h1);
        chk("stray_busy", {31'h0, busy_a}, 32'h0);
        rd(1'b0, 1'b0, 0, 16'd1000);
        rd(1'b0, 1'b1, 0, 16'd2000);

        // Out-of-range and back-to-back reads.
        rd(1'b0, 1'b0, 100, 16'h0);
        rd(1'b0, 1'b0, 57, 16'd1057);
        rd(1'b0, 1'b1, 57, 16'd2057);
        rd(1'b0, 1'b0, 127, 16'h0);
        rd(1'b0, 1'b1, 3, 16'd2003);
        repeat (3) step();
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
